strip_trigger_load_scheduler: RTL and testbench
===============================================

Name: strip_trigger_load_scheduler

Overview:
Sits between logic_pad_to_band_id / BCID alignment and strip_trigger_gen in the strip trigger path, replacing the free-running 4-clk sampling of band_id/bcid.
- Queues (band_id, bcid) trigger candidates in a small FIFO and suppresses back-to-back duplicates.
- Issues one candidate per 160 MHz slot as a single-cycle load pulse, only when the generator is ready.
- Enforces a minimum slot gap between issues and counts overflow drops.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, minimum 2; AW = log2(DEPTH).
- SLOT_DIV, 4, clk cycles per issue slot; power of 2.
- MIN_GAP, 1, idle slots required after each load before the next issue; range 0..15.
- MAX_AGE, 16, BCID age limit; used only with STRIP_SCHED_STALE_DROP_EN.

Ports:
- clk  in  1  system clock, same domain as strip_trigger_gen clk_slow.
- reset_n  in  1  asynchronous, active-low reset.
- cand_valid  in  1  one-cycle candidate strobe (data_ready).
- cand_band_id  in  8  candidate band id.
- cand_bcid  in  12  candidate BCID.
- cur_bcid  in  12  current aligned BCID; used for stale check only.
- gen_ready  in  1  strip_trigger_gen able to accept a load.
- load_out  out  1  one-cycle load pulse to strip_trigger_gen.
- band_id_out  out  8  band id; valid while load_out=1 and held afterwards.
- bcid_out  out  12  BCID; same timing as band_id_out.
- fifo_level  out  AW+1  current occupancy, 0..DEPTH.
- drop_count  out  16  overflow drops; saturates at 16'hFFFF.
- stale_count  out  16  stale discards; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, synchronous release): FIFO empty, fifo_level=0, load_out=0, band_id_out=0, bcid_out=0, both counters 0, slot counter 0, last-accepted register invalid, state IDLE.
- Slot counter: free-running 0..SLOT_DIV-1. slot_strobe is high when the count equals SLOT_DIV-1.
- Push, on a cand_valid cycle:
  - If {band_id,bcid} equals the last accepted entry and that register is valid: discard silently; no counter change.
  - Else if the FIFO is full, judged on the start-of-cycle level: drop and increment drop_count. This holds even if a pop occurs in the same cycle.
  - Else write the entry and update the last-accepted register.
- FIFO: circular, pointers wrap modulo DEPTH, registered level.
  - Simultaneous push and pop leaves the level unchanged.
  - Pop of the head is visible to the issue logic on the next cycle.
- State machine:
  - IDLE: move to WAIT when the FIFO is non-empty.
  - WAIT: on slot_strobe with gen_ready=1 and FIFO non-empty, pop the head and go to LOAD. If gen_ready=0, stay in WAIT. If the FIFO becomes empty, return to IDLE.
  - LOAD: load_out=1 for exactly this one cycle; band_id_out/bcid_out are registered at entry. If MIN_GAP=0, go to WAIT; otherwise go to GAP.
  - GAP: count MIN_GAP slot_strobes, then go to WAIT.
- Latency: a candidate pushed into an empty FIFO with gen_ready=1 in IDLE produces load_out on the cycle after the first slot_strobe that occurs at least 2 cycles after cand_valid.
- Order: strictly FIFO; no reordering.
- cand_valid arriving during LOAD/GAP is still queued normally.
- Reset mid-operation: all state and queued entries are discarded and any in-progress load pulse is cut.
- gen_ready deasserting in LOAD does not cancel the pulse already issued.

Optional Feature:
STRIP_SCHED_STALE_DROP_EN
- Defined: at pop in WAIT, compute age = (cur_bcid - entry_bcid) mod 4096.
  - If age > MAX_AGE: discard the entry, increment stale_count, stay in WAIT, and issue no load that slot.
  - Otherwise issue normally.
- Undefined: no age check; cur_bcid is unused; stale_count is tied to 0.

Test Plan:
- Single candidate: band 0x2A, bcid 0x123, gen_ready=1, cand_valid at slot count 0 -> one load_out pulse on the cycle after that slot's strobe (count 3); band_id_out=0x2A, bcid_out=0x123; fifo_level returns to 0.
- Burst of 10 distinct candidates on consecutive cycles, DEPTH=8, MIN_GAP=1 -> 8 queued, drop_count=2; 8 loads issued in order, spaced exactly 8 clk apart.
- Duplicate: same {0x05,0x0A0} strobed 3 times, then {0x06,0x0A0} -> exactly 2 loads, drop_count=0.
- Backpressure: 3 entries queued, gen_ready=0 for 40 clk then 1 -> no load while low; 3 loads afterwards; fifo_level holds 3 while stalled.
- Full plus simultaneous pop: FIFO full, cand_valid coincides with a pop -> candidate dropped, drop_count+1, fifo_level=DEPTH-1 next cycle.
- Stale (macro defined, MAX_AGE=16): entry bcid 0xFF8, cur_bcid 0x00A (age 18) -> no load, stale_count=1. Same with cur_bcid 0x000 (age 8) -> load issued.

Source files
------------

// File: rtl/strip_trigger_load_scheduler.sv
// Queues (band_id, bcid) trigger candidates and issues at most one load pulse per slot to strip_trigger_gen.
// Optional stale-BCID discard at pop time is enabled by defining STRIP_SCHED_STALE_DROP_EN.
//
// state  | meaning
// S_IDLE | FIFO empty, nothing to issue
// S_WAIT | entry pending, waiting for slot strobe with gen_ready
// S_LOAD | load_out high for this single cycle
// S_GAP  | counting MIN_GAP idle slot strobes before the next issue
module strip_trigger_load_scheduler #(
   parameter int DEPTH    = 8,
   parameter int SLOT_DIV = 4,
   parameter int MIN_GAP  = 1,
   parameter int MAX_AGE  = 16,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cand_valid,
   input  logic [7:0]    cand_band_id,
   input  logic [11:0]   cand_bcid,
   input  logic [11:0]   cur_bcid,
   input  logic          gen_ready,
   output logic          load_out,
   output logic [7:0]    band_id_out,
   output logic [11:0]   bcid_out,
   output logic [AW:0]   fifo_level,
   output logic [15:0]   drop_count,
   output logic [15:0]   stale_count
);

   localparam int SW = (SLOT_DIV > 1) ? $clog2(SLOT_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LOAD, S_GAP} state_t;

   state_t        state;
   logic [SW-1:0] slot_cnt;
   logic          slot_strobe;
   logic [19:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          last_valid;
   logic [19:0]   last_entry;
   logic [3:0]    gap_cnt;
   logic [19:0]   cand_entry;
   logic [19:0]   head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          is_dup;
   logic          push;
   logic          pop;
   logic          head_stale;
   logic          issue;

   // Slot timer counts down; the strobe is its terminal count.
   assign slot_strobe = (slot_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         slot_cnt <= SW'(SLOT_DIV - 1);
      else if (slot_strobe)
         slot_cnt <= SW'(SLOT_DIV - 1);
      else
         slot_cnt <= slot_cnt - SW'(1);
   end

   assign cand_entry = {cand_band_id, cand_bcid};
   assign head       = mem[rd_ptr];
   assign fifo_full  = (fifo_level == (AW+1)'(DEPTH));
   assign fifo_empty = (fifo_level == '0);
   assign is_dup     = last_valid && (last_entry == cand_entry);
   // Full is judged on the start-of-cycle level, so a same-cycle pop cannot make room.
   assign push       = cand_valid && !is_dup && !fifo_full;
   assign pop        = (state == S_WAIT) && slot_strobe && gen_ready && !fifo_empty;
   assign issue      = pop && !head_stale;

`ifdef STRIP_SCHED_STALE_DROP_EN
   logic [11:0] head_age;

   assign head_age   = cur_bcid - head[11:0];
   assign head_stale = (head_age > 12'(MAX_AGE));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         stale_count <= '0;
      else if (pop && head_stale && (stale_count != 16'hFFFF))
         stale_count <= stale_count + 16'd1;
   end
`else
   logic unused_stale_inputs;

   assign head_stale          = 1'b0;
   assign stale_count         = '0;
   assign unused_stale_inputs = ^{cur_bcid, 12'(MAX_AGE)};
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= cand_entry;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         last_valid <= 1'b0;
         last_entry <= '0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + AW'(1);
            last_valid <= 1'b1;
            last_entry <= cand_entry;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_level <= fifo_level + (AW+1)'(1);
         else if (!push && pop)
            fifo_level <= fifo_level - (AW+1)'(1);
         if (cand_valid && !is_dup && fifo_full && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         load_out    <= 1'b0;
         band_id_out <= '0;
         bcid_out    <= '0;
         gap_cnt     <= '0;
      end else begin
         load_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!fifo_empty)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (issue) begin
                  state       <= S_LOAD;
                  load_out    <= 1'b1;
                  band_id_out <= head[19:12];
                  bcid_out    <= head[11:0];
               end else if (fifo_empty) begin
                  state <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (MIN_GAP == 0) begin
                  state <= S_WAIT;
               end else begin
                  state   <= S_GAP;
                  gap_cnt <= 4'(MIN_GAP);
               end
            end
            S_GAP: begin
               if (slot_strobe) begin
                  if (gap_cnt == 4'd1)
                     state <= S_WAIT;
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_strip_trigger_load_scheduler.sv
// Self-checking bench for strip_trigger_load_scheduler: queue-based slot model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_strip_trigger_load_scheduler;

   localparam int DEPTH    = 8;
   localparam int SLOT_DIV = 4;
   localparam int MIN_GAP  = 1;
   localparam int MAX_AGE  = 16;
   localparam int AW       = 3;
`ifdef STRIP_SCHED_STALE_DROP_EN
   localparam bit STALE_EN = 1'b1;
`else
   localparam bit STALE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cand_valid = 1'b0;
   logic [7:0]    cand_band_id = '0;
   logic [11:0]   cand_bcid = '0;
   logic [11:0]   cur_bcid = '0;
   logic          gen_ready = 1'b0;
   logic          load_out;
   logic [7:0]    band_id_out;
   logic [11:0]   bcid_out;
   logic [AW:0]   fifo_level;
   logic [15:0]   drop_count;
   logic [15:0]   stale_count;

   always #5 clk = ~clk;

   strip_trigger_load_scheduler #(
      .DEPTH(DEPTH), .SLOT_DIV(SLOT_DIV), .MIN_GAP(MIN_GAP), .MAX_AGE(MAX_AGE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cand_valid(cand_valid), .cand_band_id(cand_band_id),
      .cand_bcid(cand_bcid), .cur_bcid(cur_bcid), .gen_ready(gen_ready), .load_out(load_out),
      .band_id_out(band_id_out), .bcid_out(bcid_out), .fifo_level(fifo_level),
      .drop_count(drop_count), .stale_count(stale_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of pending candidates with their push cycle, and slot arithmetic for issue timing.
   typedef struct {
      logic [7:0]  band;
      logic [11:0] bcid;
      int          pcyc;
   } ent_t;

   ent_t        q[$];
   int          cyc;
   int          next_ok;
   bit          last_v;
   logic [19:0] last_d;
   logic        exp_load;
   logic [7:0]  exp_band;
   logic [11:0] exp_bcid;
   int          exp_drop;
   int          exp_stale;
   int          log_cyc[$];
   logic [7:0]  log_band[$];
   logic [11:0] log_bcid[$];

   task automatic model_reset();
      q.delete();
      cyc       = 0;
      next_ok   = 0;
      last_v    = 1'b0;
      last_d    = '0;
      exp_load  = 1'b0;
      exp_band  = '0;
      exp_bcid  = '0;
      exp_drop  = 0;
      exp_stale = 0;
   endtask

   task automatic model_step();
      ent_t        h;
      int          lvl0;
      logic [11:0] age;
      bit          take;
      lvl0 = q.size();
      take = ((cyc % SLOT_DIV) == SLOT_DIV - 1) && gen_ready && (lvl0 > 0) && (cyc >= next_ok);
      if (take)
         take = (q[0].pcyc <= cyc - 2);
      exp_load = 1'b0;
      if (take) begin
         h   = q.pop_front();
         age = cur_bcid - h.bcid;
         if (STALE_EN && (age > 12'(MAX_AGE))) begin
            if (exp_stale < 65535) exp_stale++;
         end else begin
            exp_load = 1'b1;
            exp_band = h.band;
            exp_bcid = h.bcid;
            next_ok  = cyc + SLOT_DIV * (MIN_GAP + 1);
            log_cyc.push_back(cyc + 1);
            log_band.push_back(h.band);
            log_bcid.push_back(h.bcid);
         end
      end
      if (cand_valid && !(last_v && (last_d == {cand_band_id, cand_bcid}))) begin
         if (lvl0 == DEPTH) begin
            if (exp_drop < 65535) exp_drop++;
         end else begin
            h.band = cand_band_id;
            h.bcid = cand_bcid;
            h.pcyc = cyc;
            q.push_back(h);
            last_v = 1'b1;
            last_d = {cand_band_id, cand_bcid};
         end
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         model_reset();
         chk("rst_load_out", 32'(load_out), 32'd0);
         chk("rst_band_id_out", 32'(band_id_out), 32'd0);
         chk("rst_bcid_out", 32'(bcid_out), 32'd0);
         chk("rst_fifo_level", 32'(fifo_level), 32'd0);
         chk("rst_drop_count", 32'(drop_count), 32'd0);
         chk("rst_stale_count", 32'(stale_count), 32'd0);
      end else begin
         chk("load_out", 32'(load_out), 32'(exp_load));
         chk("band_id_out", 32'(band_id_out), 32'(exp_band));
         chk("bcid_out", 32'(bcid_out), 32'(exp_bcid));
         chk("fifo_level", 32'(fifo_level), 32'(q.size()));
         chk("drop_count", 32'(drop_count), 32'(exp_drop));
         chk("stale_count", 32'(stale_count), 32'(exp_stale));
         model_step();
      end
   end

   int tcyc;

   task automatic step();
      @(posedge clk);
      #1;
      tcyc++;
   endtask

   task automatic run_to(input int c);
      while (tcyc < c) step();
   endtask

   task automatic cand(input logic [7:0] b, input logic [11:0] id);
      cand_valid   = 1'b1;
      cand_band_id = b;
      cand_bcid    = id;
      step();
      cand_valid   = 1'b0;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      cand_valid = 1'b0;
      gen_ready  = 1'b0;
      cur_bcid   = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tcyc    = 0;
      log_cyc.delete();
      log_band.delete();
      log_bcid.delete();
   endtask

   initial begin
      // Single candidate; gen_ready dropping during the pulse must not cut it.
      do_reset();
      gen_ready = 1'b1;
      cand(8'h2A, 12'h123);
      run_to(4);
      chk("t1_pulse_high", 32'(load_out), 32'd1);
      gen_ready = 1'b0;
      run_to(5);
      chk("t1_pulse_single", 32'(load_out), 32'd0);
      gen_ready = 1'b1;
      run_to(20);
      chk("t1_load_count", 32'(log_cyc.size()), 32'd1);
      chk("t1_load_cycle", 32'(log_cyc[0]), 32'd4);
      chk("t1_band_held", 32'(band_id_out), 32'h2A);
      chk("t1_bcid_held", 32'(bcid_out), 32'h123);
      chk("t1_level_empty", 32'(fifo_level), 32'd0);

      // Burst of 10 into a stalled FIFO, then a candidate coinciding with the first pop while full.
      do_reset();
      for (int i = 0; i < 10; i++)
         cand(8'(8'h10 + i), 12'(12'h200 + i));
      chk("t2_level_full", 32'(fifo_level), 32'd8);
      chk("t2_drops", 32'(drop_count), 32'd2);
      gen_ready = 1'b1;
      step();
      cand(8'h77, 12'h777);
      chk("t2_level_after_pop", 32'(fifo_level), 32'd7);
      chk("t2_drop_full_pop", 32'(drop_count), 32'd3);
      run_to(80);
      chk("t2_load_count", 32'(log_cyc.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("t2_load_cycle", 32'(log_cyc[i]), 32'(12 + 8 * i));
         chk("t2_load_band", 32'(log_band[i]), 32'(8'h10 + i));
         chk("t2_load_bcid", 32'(log_bcid[i]), 32'(12'h200 + i));
      end

      // Back-to-back duplicates are suppressed.
      do_reset();
      gen_ready = 1'b1;
      repeat (3) cand(8'h05, 12'h0A0);
      cand(8'h06, 12'h0A0);
      run_to(30);
      chk("t3_load_count", 32'(log_cyc.size()), 32'd2);
      chk("t3_first_cycle", 32'(log_cyc[0]), 32'd4);
      chk("t3_second_cycle", 32'(log_cyc[1]), 32'd12);
      chk("t3_second_band", 32'(log_band[1]), 32'h06);
      chk("t3_drops", 32'(drop_count), 32'd0);

      // Backpressure: nothing issues while gen_ready is low.
      do_reset();
      cand(8'h41, 12'h100);
      cand(8'h42, 12'h101);
      cand(8'h43, 12'h102);
      run_to(20);
      chk("t4_level_stalled", 32'(fifo_level), 32'd3);
      run_to(40);
      chk("t4_level_stalled_end", 32'(fifo_level), 32'd3);
      chk("t4_no_load_stalled", 32'(log_cyc.size()), 32'd0);
      gen_ready = 1'b1;
      run_to(70);
      chk("t4_load_count", 32'(log_cyc.size()), 32'd3);
      chk("t4_cycle0", 32'(log_cyc[0]), 32'd44);
      chk("t4_cycle1", 32'(log_cyc[1]), 32'd52);
      chk("t4_cycle2", 32'(log_cyc[2]), 32'd60);
      chk("t4_band2", 32'(log_band[2]), 32'h43);

      // Stale BCID: age 18 then age 8.
      do_reset();
      gen_ready = 1'b1;
      cur_bcid  = 12'h00A;
      cand(8'h11, 12'hFF8);
      run_to(20);
      cur_bcid = 12'h000;
      cand(8'h12, 12'hFF8);
      run_to(40);
`ifdef STRIP_SCHED_STALE_DROP_EN
      chk("t5_load_count", 32'(log_cyc.size()), 32'd1);
      chk("t5_load_band", 32'(log_band[0]), 32'h12);
      chk("t5_load_cycle", 32'(log_cyc[0]), 32'd24);
      chk("t5_stale_count", 32'(stale_count), 32'd1);
`else
      chk("t5_load_count", 32'(log_cyc.size()), 32'd2);
      chk("t5_load_cycle0", 32'(log_cyc[0]), 32'd4);
      chk("t5_load_cycle1", 32'(log_cyc[1]), 32'd24);
      chk("t5_stale_count", 32'(stale_count), 32'd0);
`endif

      // Reset in the middle of a load pulse cuts it and empties the queue.
      do_reset();
      gen_ready = 1'b1;
      cand(8'h33, 12'h333);
      cand(8'h34, 12'h334);
      run_to(4);
      chk("t6_pulse_before_reset", 32'(load_out), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t6_pulse_cut", 32'(load_out), 32'd0);
      chk("t6_level_cleared", 32'(fifo_level), 32'd0);
      chk("t6_band_cleared", 32'(band_id_out), 32'd0);
      do_reset();
      gen_ready = 1'b1;
      run_to(20);
      chk("t6_no_load_after_reset", 32'(log_cyc.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
